// File: rtl/motor_thres_ramp_pkg.sv
// Shared definitions for the motor threshold ramp and the PWM generator.
package motor_thres_ramp_pkg;

  localparam int unsigned THRES_W = 16;
  localparam int unsigned CNT_W   = 8;

  localparam logic [THRES_W-1:0] RAMP_STEP_DEF    = 16'd50;
  localparam logic [THRES_W-1:0] THRES_MIN_DEF    = 16'd51;
  localparam logic [THRES_W-1:0] THRES_MAX_DEF    = 16'd2501;
  localparam logic [CNT_W-1:0]   DEAD_PERIODS_DEF = 8'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_DECEL = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  // Accepted speed request: clamped threshold plus direction (1 = forward).
  typedef struct packed {
    logic [THRES_W-1:0] thres;
    logic               dir;
  } cmd_t;

endpackage

// File: rtl/motor_thres_ramp_thres_step_calc.sv
// Combinational clamp of requested thresholds and the per-period step toward a target.
module thres_step_calc
  import motor_thres_ramp_pkg::*;
#(
  parameter logic [THRES_W-1:0] RAMP_STEP = RAMP_STEP_DEF,
  parameter logic [THRES_W-1:0] THRES_MIN = THRES_MIN_DEF,
  parameter logic [THRES_W-1:0] THRES_MAX = THRES_MAX_DEF
) (
  input  logic [THRES_W-1:0] i_cmd_thres,
  input  logic [THRES_W-1:0] i_cur,
  input  logic [THRES_W-1:0] i_target,
  output logic [THRES_W-1:0] o_clamped_c,
  output logic [THRES_W-1:0] o_ramp_nxt_c,
  output logic [THRES_W-1:0] o_decel_nxt_c
);

  logic [THRES_W:0]   w_diff;
  logic [THRES_W-1:0] w_mag;
  logic [THRES_W-1:0] w_rstep;
  logic [THRES_W-1:0] w_dstep;

  // Clamp a request into the legal range; zero means stop and passes through.
  always_comb begin
    o_clamped_c = i_cmd_thres;
    if (i_cmd_thres == '0) begin
      o_clamped_c = '0;
    end else if (i_cmd_thres < THRES_MIN) begin
      o_clamped_c = THRES_MIN;
    end else if (i_cmd_thres > THRES_MAX) begin
      o_clamped_c = THRES_MAX;
    end
  end

  // Signed distance kept one bit wider so a downward move cannot wrap.
  always_comb begin
    w_diff       = {1'b0, i_target} - {1'b0, i_cur};
    w_mag        = THRES_W'(w_diff[THRES_W] ? ((THRES_W + 1)'(0) - w_diff) : w_diff);
    w_rstep      = (w_mag > RAMP_STEP) ? RAMP_STEP : w_mag;
    o_ramp_nxt_c = w_diff[THRES_W] ? (i_cur - w_rstep) : (i_cur + w_rstep);
  end

  // Deceleration step toward zero, never below zero.
  always_comb begin
    w_dstep       = (i_cur > RAMP_STEP) ? RAMP_STEP : i_cur;
    o_decel_nxt_c = i_cur - w_dstep;
  end

endmodule

// File: rtl/motor_thres_ramp.sv
// Slews the PWM threshold toward the requested speed once per PWM period and
// sequences direction reversals through zero with a dead interval.
module motor_thres_ramp
  import motor_thres_ramp_pkg::*;
#(
  parameter logic [THRES_W-1:0] RAMP_STEP    = RAMP_STEP_DEF,
  parameter logic [THRES_W-1:0] THRES_MIN    = THRES_MIN_DEF,
  parameter logic [THRES_W-1:0] THRES_MAX    = THRES_MAX_DEF,
  parameter logic [CNT_W-1:0]   DEAD_PERIODS = DEAD_PERIODS_DEF
) (
  input  logic               in_clk,
  input  logic               in_rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [THRES_W-1:0] cmd_thres,
  input  logic               cmd_dir,
  input  logic               period_start,
  output logic [THRES_W-1:0] pwm_thres,
  output logic               dir_out,
  output logic               busy
);

  state_t             r_state;
  cmd_t               r_target;
  logic [THRES_W-1:0] r_thres;
  logic               r_dir;
  logic [CNT_W-1:0]   r_dead_cnt;
  logic               r_busy;
  logic               r_cmd_ready;

  state_t             w_state_nxt;
  logic [THRES_W-1:0] w_thres_nxt;
  logic               w_dir_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [THRES_W-1:0] w_clamped;
  logic [THRES_W-1:0] w_ramp_nxt;
  logic [THRES_W-1:0] w_decel_nxt;

  thres_step_calc #(
    .RAMP_STEP (RAMP_STEP),
    .THRES_MIN (THRES_MIN),
    .THRES_MAX (THRES_MAX)
  ) u_step (
    .i_cmd_thres   (cmd_thres),
    .i_cur         (r_thres),
    .i_target      (r_target.thres),
    .o_clamped_c   (w_clamped),
    .o_ramp_nxt_c  (w_ramp_nxt),
    .o_decel_nxt_c (w_decel_nxt)
  );

  // State, output and command registers.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      r_state     <= ST_IDLE;
      r_target    <= '{thres: '0, dir: 1'b1};
      r_thres     <= '0;
      r_dir       <= 1'b1;
      r_dead_cnt  <= '0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_thres     <= w_thres_nxt;
      r_dir       <= w_dir_nxt;
      r_dead_cnt  <= w_cnt_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_cmd_ready <= 1'b1;
      if (cmd_valid && r_cmd_ready) begin
        r_target <= '{thres: w_clamped, dir: cmd_dir};
      end
    end
  end

  // Next-state logic; steps only on a period start, direction flips only at zero.
  always_comb begin
    w_state_nxt = r_state;
    w_thres_nxt = r_thres;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_dead_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (r_target.dir != r_dir) begin
          w_state_nxt = ST_DECEL;
        end else if (r_target.thres != r_thres) begin
          w_state_nxt = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (r_target.dir != r_dir) begin
          w_state_nxt = ST_DECEL;
        end else if (r_target.thres == r_thres) begin
          w_state_nxt = ST_IDLE;
        end else if (period_start) begin
          w_thres_nxt = w_ramp_nxt;
          if (w_ramp_nxt == r_target.thres) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DECEL: begin
        if (r_thres == '0) begin
          w_cnt_nxt   = DEAD_PERIODS;
          w_state_nxt = ST_DEAD;
        end else if (period_start) begin
          w_thres_nxt = w_decel_nxt;
          if (w_decel_nxt == '0) begin
            w_cnt_nxt   = DEAD_PERIODS;
            w_state_nxt = ST_DEAD;
          end
        end
      end
      ST_DEAD: begin
        w_thres_nxt = '0;
        if (r_dead_cnt == '0) begin
          w_dir_nxt   = r_target.dir;
          w_state_nxt = ST_RAMP;
        end else if (period_start) begin
          w_cnt_nxt = r_dead_cnt - CNT_W'(1);
          if (r_dead_cnt == CNT_W'(1)) begin
            w_dir_nxt   = r_target.dir;
            w_state_nxt = ST_RAMP;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready = r_cmd_ready;
  assign pwm_thres = r_thres;
  assign dir_out   = r_dir;
  assign busy      = r_busy;

endmodule

// File: tb/tb_motor_thres_ramp.sv
// Scoreboard bench for motor_thres_ramp: expected output after each period
// pulse is queued when the pulse is driven and compared one edge later.
module tb_motor_thres_ramp;

  localparam int GAP = 3;

  typedef struct packed {
    logic [15:0] thres;
    logic        dir;
    logic        busy;
  } exp_t;

  logic        in_clk = 1'b0;
  logic        in_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_thres = 16'd0;
  logic        cmd_dir = 1'b1;
  logic        period_start = 1'b0;
  logic [15:0] pwm_thres;
  logic        dir_out;
  logic        busy;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  motor_thres_ramp dut (
    .in_clk       (in_clk),
    .in_rst_n     (in_rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_thres    (cmd_thres),
    .cmd_dir      (cmd_dir),
    .period_start (period_start),
    .pwm_thres    (pwm_thres),
    .dir_out      (dir_out),
    .busy         (busy)
  );

  always #5 in_clk = ~in_clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Compare queued expectations one step after each sampled period pulse.
  always @(posedge in_clk) begin
    if (period_start && in_rst_n) begin
      #1;
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("pwm_thres", 32'(pwm_thres), 32'(e.thres));
        check_eq("dir_out", 32'(dir_out), 32'(e.dir));
        check_eq("busy", 32'(busy), 32'(e.busy));
      end
    end
  end

  task automatic send(input logic [15:0] t, input logic d);
    @(negedge in_clk);
    cmd_valid = 1'b1;
    cmd_thres = t;
    cmd_dir   = d;
    @(negedge in_clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge in_clk);
  endtask

  task automatic tick(input logic [15:0] et, input logic ed, input logic eb);
    @(negedge in_clk);
    period_start = 1'b1;
    sb.push_back('{thres: et, dir: ed, busy: eb});
    @(negedge in_clk);
    period_start = 1'b0;
    repeat (GAP) @(negedge in_clk);
  endtask

  // Period pulse coinciding with a new command; the step must use the old target.
  task automatic tick_cmd(input logic [15:0] t, input logic d,
                          input logic [15:0] et, input logic ed, input logic eb);
    @(negedge in_clk);
    period_start = 1'b1;
    cmd_valid    = 1'b1;
    cmd_thres    = t;
    cmd_dir      = d;
    sb.push_back('{thres: et, dir: ed, busy: eb});
    @(negedge in_clk);
    period_start = 1'b0;
    cmd_valid    = 1'b0;
    repeat (GAP) @(negedge in_clk);
  endtask

  task automatic do_reset();
    @(negedge in_clk);
    in_rst_n = 1'b0;
    repeat (2) @(negedge in_clk);
    in_rst_n = 1'b1;
    @(negedge in_clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge in_clk);
    check_eq("rst_pwm", 32'(pwm_thres), 32'd0);
    check_eq("rst_dir", 32'(dir_out), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    in_rst_n = 1'b1;
    @(negedge in_clk);

    // Up-ramp to 1000 in 20 periods
    send(16'd1000, 1'b1);
    check_eq("ramp_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 20; k++) tick(16'(50 * k), 1'b1, (k < 20));

    // Non-multiple step; nothing moves without a period pulse
    send(16'd1020, 1'b1);
    repeat (5) @(negedge in_clk);
    check_eq("hold_no_pulse", 32'(pwm_thres), 32'd1000);
    check_eq("hold_busy", 32'(busy), 32'd1);
    tick(16'd1020, 1'b1, 1'b0);

    // Clamp low: 20 -> 51
    do_reset();
    send(16'd20, 1'b1);
    tick(16'd50, 1'b1, 1'b1);
    tick(16'd51, 1'b1, 1'b0);
    // Clamp high: 5000 -> 2501
    send(16'd5000, 1'b1);
    for (int k = 1; k <= 49; k++) tick(16'(51 + 50 * k), 1'b1, (k < 49));
    tick(16'd2501, 1'b1, 1'b0);

    // Stop from 120
    do_reset();
    send(16'd120, 1'b1);
    tick(16'd50, 1'b1, 1'b1);
    tick(16'd100, 1'b1, 1'b1);
    tick(16'd120, 1'b1, 1'b0);
    send(16'd0, 1'b1);
    tick(16'd70, 1'b1, 1'b1);
    tick(16'd20, 1'b1, 1'b1);
    tick(16'd0, 1'b1, 1'b0);

    // Reversal from 200 forward to 300 reverse
    do_reset();
    send(16'd200, 1'b1);
    for (int k = 1; k <= 4; k++) tick(16'(50 * k), 1'b1, (k < 4));
    send(16'd300, 1'b0);
    tick(16'd150, 1'b1, 1'b1);
    tick(16'd100, 1'b1, 1'b1);
    tick(16'd50, 1'b1, 1'b1);
    tick(16'd0, 1'b1, 1'b1);
    for (int k = 1; k <= 4; k++) tick(16'd0, 1'b1, 1'b1);
    tick(16'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) tick(16'(50 * k), 1'b0, (k < 6));

    // Simultaneous command and period pulse, then reset mid-deceleration
    send(16'd500, 1'b0);
    tick(16'd350, 1'b0, 1'b1);
    tick_cmd(16'd360, 1'b0, 16'd400, 1'b0, 1'b1);
    tick(16'd360, 1'b0, 1'b0);
    send(16'd100, 1'b1);
    tick(16'd310, 1'b0, 1'b1);
    tick(16'd260, 1'b0, 1'b1);
    @(negedge in_clk);
    in_rst_n = 1'b0;
    @(posedge in_clk);
    #1;
    check_eq("midrst_pwm", 32'(pwm_thres), 32'd0);
    check_eq("midrst_dir", 32'(dir_out), 32'd1);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    repeat (2) @(negedge in_clk);
    tick(16'd0, 1'b1, 1'b0);

    // Retarget mid-ramp: 1000 requested, 300 requested at 400
    send(16'd1000, 1'b1);
    for (int k = 1; k <= 8; k++) tick(16'(50 * k), 1'b1, 1'b1);
    send(16'd300, 1'b1);
    tick(16'd350, 1'b1, 1'b1);
    tick(16'd300, 1'b1, 1'b0);
    repeat (5) @(negedge in_clk);
    check_eq("final_pwm", 32'(pwm_thres), 32'd300);

    repeat (3) @(negedge in_clk);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/motor_thres_ramp.md
Name: motor_thres_ramp

Overview:
Upstream stage of the motor PWM generator. Accepts a requested speed (threshold) and direction from the register interface and slews the generator's pwm_thres input by at most RAMP_STEP per PWM period, using the generator's period-start pulse as its tick. On a direction reversal it ramps to zero, holds a dead interval, flips the direction output, then ramps back up. This bounds motor current spikes and prevents H-bridge shoot-through.

Parameters:
RAMP_STEP, 16'd50, maximum threshold change per PWM period (must be >= 1)
THRES_MIN, 16'd51, smallest nonzero threshold; nonzero requests below this clamp up to it
THRES_MAX, 16'd2501, largest threshold; requests above this clamp down to it
DEAD_PERIODS, 8'd5, PWM periods held at zero before the direction flips

Ports:
in_clk  input  1  system clock
in_rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  new target present
cmd_ready  output  1  target accepted this cycle when cmd_valid is also high
cmd_thres  input  16  requested threshold; 0 means stop
cmd_dir  input  1  requested direction (1 = forward)
period_start  input  1  one-cycle pulse at each PWM period start, from the generator
pwm_thres  output  16  threshold driven to the PWM generator
dir_out  output  1  direction to the H-bridge
busy  output  1  high while pwm_thres != target or a reversal is in progress

Behaviour:
- Clocking: one clock, in_clk. Reset is synchronous and active-low on in_rst_n.
- Reset values: pwm_thres=0, dir_out=1, busy=0, cmd_ready=1, state=IDLE, target=0, target_dir=1, dead counter=0.
- Command capture: cmd_ready is always 1, so new targets are always accepted. A handshake registers the clamped target and target_dir on the next edge. A later handshake overwrites the earlier one, including mid-ramp and mid-reversal.
- Clamping: 0 stays 0. Values 1..THRES_MIN-1 become THRES_MIN. Values above THRES_MAX become THRES_MAX.
- States and transitions:
  - IDLE: pwm_thres == target and dir_out == target_dir. Go to RAMP when target != pwm_thres and target_dir == dir_out. Go to DECEL when target_dir != dir_out.
  - RAMP: on each period_start, move pwm_thres toward target by min(RAMP_STEP, |target - pwm_thres|). Go to IDLE on the edge where pwm_thres reaches target. If target_dir changes while in RAMP, go to DECEL.
  - DECEL: on each period_start, subtract min(RAMP_STEP, pwm_thres) from pwm_thres. When pwm_thres reaches 0, load the dead counter with DEAD_PERIODS and go to DEAD.
  - DEAD: pwm_thres holds 0. Decrement the counter on each period_start. At 0, set dir_out = target_dir and go to RAMP. If target_dir was changed back to dir_out during DEAD, still complete the dead time, then go to RAMP with no flip.
- Monotonic output: between two period_start pulses, pwm_thres changes by at most RAMP_STEP.
- Ramping up from 0: the first step is min(RAMP_STEP, target); THRES_MIN is not enforced on the ramp path.
- Arithmetic: compute the difference in 17 bits to avoid wrap-around. The output never underflows below 0 or overshoots target.
- Timing: pwm_thres and dir_out update on the clock edge after period_start is sampled high, so latency is 1 cycle. dir_out changes only while pwm_thres == 0.
- Simultaneous events: if cmd_valid and period_start are high in the same cycle, the step uses the old target and the new target takes effect from the next period.
- Reset mid-operation: return immediately to the reset values; no ramp-down.
- busy = (state != IDLE).

Decomposition:
- Shared package: state encoding (IDLE, RAMP, DECEL, DEAD) and the default THRES_MIN/THRES_MAX constants shared with the PWM generator.
- One natural sub-module, thres_step_calc: combinational clamp-and-step arithmetic (17-bit difference, min with RAMP_STEP, direction of the step).
- FSM and registers stay in the top module.

Test Plan:
- Up-ramp: reset, command 1000 forward, pulse period_start every 100 cycles -> pwm_thres = 50, 100, ... 1000 after 20 periods; busy falls on the 1000 edge; dir_out stays 1.
- Clamping: command 20 -> target becomes 51. Command 5000 -> target becomes 2501. Command 0 from 120 -> output 70, 20, 0.
- Reversal: at 200 forward, command 300 reverse -> output 150, 100, 50, 0; held 0 for 5 periods; dir_out flips to 0 one cycle after the 5th pulse; then 50 ... 300.
- Retarget mid-ramp: ramping toward 1000, at 400 command 300 -> next step goes to 350, then 300; no overshoot.
- Simultaneous cmd_valid and period_start, plus in_rst_n pulled low mid-DECEL -> step uses the old target; reset clears pwm_thres to 0 and dir_out to 1 on the next edge.
- Non-multiple step: target 1020 from 1000 -> a single step of 20; no pwm_thres change occurs without a period_start.
